// File: rtl/arr_pattern_pkg.sv
// arr_pattern_pkg: shared types and helpers for arr_pattern_gen.
//   mode_e       - pattern select (xorshift, walking-one, beat counter, constant seed)
//   state_e      - burst FSM states
//   SEED_DEFAULT - reset seed used when no other seed is provided
//   xorshift64   - one 64-bit xorshift step (13 / 7 / 17)
package arr_pattern_pkg;

  localparam logic [63:0] SEED_DEFAULT = 64'h9E37_79B9_7F4A_7C15;

  typedef enum logic [1:0] {
    MODE_XORSHIFT = 2'd0,
    MODE_WALK     = 2'd1,
    MODE_COUNT    = 2'd2,
    MODE_CONST    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic [63:0] xorshift64(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

endpackage

// File: rtl/apg_channel_map.sv
// apg_channel_map: derives one channel's beat from the shared 64-bit pattern word.
//   pattern_i - pattern word P for the current beat
//   data_o    - low LANES*LANE_W bits of P rotated left by 8*CH_IDX (mod 64)
module apg_channel_map #(
  parameter int unsigned CH_IDX = 0,
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 5
) (
  input  logic [63:0]                  pattern_i,
  output logic [LANES-1:0][LANE_W-1:0] data_o
);

  localparam int unsigned ROT = (8 * CH_IDX) % 64;
  localparam int unsigned W   = LANES * LANE_W;

  // For ROT=0 both shifts are zero and the OR returns the word unchanged.
  always_comb begin
    data_o = W'((pattern_i << ROT) | (pattern_i >> ((64 - ROT) % 64)));
  end

endmodule

// File: rtl/arr_pattern_gen.sv
// arr_pattern_gen: burst pattern generator with valid/ready output.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, mode, len    - begin a burst of len beats (0 = 65536) in the given mode
//   seed_load, seed_in  - load a new state seed while idle (0 selects SEED)
//   out_ready           - consumer ready
//   out_valid, out_data - beat handshake and per-channel packed beat data
//   busy, done          - burst in progress, one-cycle end-of-burst pulse
//   beat_cnt            - beats accepted in the current or last burst
module arr_pattern_gen
  import arr_pattern_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned LANES    = 4,
  parameter int unsigned LANE_W   = 5,
  parameter logic [63:0] SEED     = SEED_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [15:0]                  len,
  input  logic                         seed_load,
  input  logic [63:0]                  seed_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [LANES-1:0][LANE_W-1:0] out_data [CHANNELS],
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  beat_cnt
);

  localparam int unsigned PW = LANES * LANE_W;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("arr_pattern_gen: CHANNELS must be 1..8");
  end
  if (PW < 1 || PW > 64) begin : g_bad_width
    $error("arr_pattern_gen: LANES*LANE_W must be 1..64");
  end
  if (SEED == 64'd0) begin : g_bad_seed
    $error("arr_pattern_gen: SEED must be non-zero");
  end

  state_e      state_q;
  mode_e       mode_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [63:0] s_q;
  logic [63:0] p_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic        accept;
  logic        last;
  logic [63:0] s_idle;
  logic [63:0] s_step;
  logic [15:0] cnt_inc;

  function automatic logic [63:0] pattern(input mode_e m, input logic [63:0] s,
                                          input logic [15:0] cnt);
    case (m)
      MODE_WALK:  pattern = 64'd1 << (32'(cnt) % PW);
      MODE_COUNT: pattern = {48'd0, cnt};
      default:    pattern = s;
    endcase
  endfunction

  always_comb begin
    accept  = valid_q && out_ready;
    // len_q-1 wraps to 65535 when len_q is 0, giving a 65536-beat burst.
    last    = (cnt_q == len_q - 16'd1);
    cnt_inc = cnt_q + 16'd1;
    s_idle  = seed_load ? ((seed_in == '0) ? SEED : seed_in) : s_q;
    s_step  = (mode_q == MODE_XORSHIFT) ? xorshift64(s_q) : s_q;
  end

  // p_q holds the pattern word of the beat on the bus; it is only rewritten
  // on start or acceptance, so data stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_XORSHIFT;
      len_q   <= '0;
      cnt_q   <= '0;
      s_q     <= SEED;
      p_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          s_q <= s_idle;
          if (start) begin
            mode_q  <= mode_e'(mode);
            len_q   <= len;
            cnt_q   <= '0;
            p_q     <= pattern(mode_e'(mode), s_idle, 16'd0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            s_q   <= s_step;
            cnt_q <= cnt_inc;
            if (last) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              p_q <= pattern(mode_q, s_step, cnt_inc);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    apg_channel_map #(
      .CH_IDX(c),
      .LANES (LANES),
      .LANE_W(LANE_W)
    ) u_map (
      .pattern_i(p_q),
      .data_o   (out_data[c])
    );
  end

  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_arr_pattern_gen.sv
// tb_arr_pattern_gen: directed self-checking bench for arr_pattern_gen
// (CHANNELS=2, LANES=4, LANE_W=5, default SEED).
module tb_arr_pattern_gen;

  localparam int unsigned CH = 2;
  localparam int unsigned LN = 4;
  localparam int unsigned LW = 5;
  localparam logic [63:0] SEEDV = 64'h9E37_79B9_7F4A_7C15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] len = 16'd0;
  logic        seed_load = 1'b0;
  logic [63:0] seed_in = 64'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [15:0] beat_cnt;
  logic [LN-1:0][LW-1:0] out_data [CH];

  logic [19:0] d0;
  logic [19:0] d1;
  assign d0 = out_data[0];
  assign d1 = out_data[1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arr_pattern_gen #(
    .CHANNELS(CH),
    .LANES   (LN),
    .LANE_W  (LW),
    .SEED    (SEEDV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt)
  );

  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge where the first beat is on the bus.
  task automatic start_burst(input logic [1:0] m, input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    int b;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_cnt",   64'(beat_cnt),  64'd0);
    chk("rst_d0",    64'(d0),        64'd0);
    chk("rst_d1",    64'(d1),        64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Mode 0, len 3
    start_burst(2'd0, 16'd3);
    chk("m0_valid", 64'(out_valid), 64'd1);
    chk("m0_busy",  64'(busy),      64'd1);
    chk("m0_b0_ch1", 64'(d1), 64'h0_0000_000C_159E);
    m = SEEDV;
    for (int k = 0; k < 3; k++) begin
      chk("m0_d0",  64'(d0), 64'(m[19:0]));
      chk("m0_cnt", 64'(beat_cnt), 64'(k));
      m = xs(m);
      @(negedge clk);
    end
    chk("m0_b0_seed_slice", 64'h0A7C15, 64'(SEEDV[19:0]));
    chk("m0_done",       64'(done),      64'd1);
    chk("m0_done_valid", 64'(out_valid), 64'd0);
    chk("m0_done_busy",  64'(busy),      64'd0);
    chk("m0_done_cnt",   64'(beat_cnt),  64'd3);
    @(negedge clk);
    chk("m0_done_once",  64'(done),      64'd0);
    chk("m0_cnt_hold",   64'(beat_cnt),  64'd3);

    // Mode 1 walking one, len 22
    start_burst(2'd1, 16'd22);
    for (int k = 0; k < 22; k++) begin
      b = (k < 20) ? k : k - 20;
      chk("m1_d0", 64'(d0), 64'(20'd1 << b));
      chk("m1_d1", 64'(d1), (b < 12) ? 64'(20'd1 << (b + 8)) : 64'd0);
      @(negedge clk);
    end
    chk("m1_done", 64'(done),     64'd1);
    chk("m1_cnt",  64'(beat_cnt), 64'd22);

    // Mode 2 counter, len 5, stall at beat 2
    start_burst(2'd2, 16'd5);
    chk("m2_b0", 64'(d0), 64'd0);
    @(negedge clk);
    chk("m2_b1", 64'(d0), 64'd1);
    @(negedge clk);
    chk("m2_b2", 64'(d0), 64'd2);
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("m2_hold_d0",    64'(d0),        64'd2);
      chk("m2_hold_valid", 64'(out_valid), 64'd1);
      chk("m2_hold_cnt",   64'(beat_cnt),  64'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("m2_b3", 64'(d0), 64'd3);
    @(negedge clk);
    chk("m2_b4", 64'(d0), 64'd4);
    @(negedge clk);
    chk("m2_done", 64'(done),     64'd1);
    chk("m2_cnt",  64'(beat_cnt), 64'd5);

    // seed_load with start together, mode 3; seed_load during RUN ignored
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 64'h0123_4567_89AB_CDEF;
    start     = 1'b1;
    mode      = 2'd3;
    len       = 16'd3;
    @(negedge clk);
    start     = 1'b0;
    chk("sl_b0_d0", 64'(d0), 64'h0BCDEF);
    chk("sl_b0_d1", 64'(d1), 64'hDEF01);
    seed_in   = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    seed_load = 1'b0;
    chk("sl_b1_d0", 64'(d0), 64'h0BCDEF);
    @(negedge clk);
    chk("sl_b2_d0", 64'(d0), 64'h0BCDEF);
    chk("sl_b2_d1", 64'(d1), 64'hDEF01);
    @(negedge clk);
    chk("sl_done", 64'(done), 64'd1);
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 64'd0;
    @(negedge clk);
    seed_load = 1'b0;
    start_burst(2'd3, 16'd3);
    for (int k = 0; k < 3; k++) begin
      chk("m3_d0", 64'(d0), 64'h0A7C15);
      chk("m3_d1", 64'(d1), 64'hC159E);
      @(negedge clk);
    end
    chk("m3_done", 64'(done), 64'd1);

    // start during RUN is ignored
    start_burst(2'd2, 16'd6);
    chk("sr_b0", 64'(d0), 64'd0);
    @(negedge clk);
    chk("sr_b1", 64'(d0), 64'd1);
    @(negedge clk);
    chk("sr_b2", 64'(d0), 64'd2);
    start = 1'b1;
    mode  = 2'd1;
    len   = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("sr_b3",   64'(d0),       64'd3);
    chk("sr_cnt3", 64'(beat_cnt), 64'd3);
    chk("sr_busy", 64'(busy),     64'd1);
    @(negedge clk);
    chk("sr_b4", 64'(d0), 64'd4);
    @(negedge clk);
    chk("sr_b5", 64'(d0), 64'd5);
    @(negedge clk);
    chk("sr_done", 64'(done),     64'd1);
    chk("sr_cnt",  64'(beat_cnt), 64'd6);

    // Asynchronous reset mid-burst
    start_burst(2'd2, 16'd10);
    @(negedge clk);
    chk("ar_b1", 64'(d0), 64'd1);
    @(negedge clk);
    chk("ar_b2", 64'(d0), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_busy",  64'(busy),      64'd0);
    chk("ar_done",  64'(done),      64'd0);
    chk("ar_cnt",   64'(beat_cnt),  64'd0);
    chk("ar_d0",    64'(d0),        64'd0);
    chk("ar_d1",    64'(d1),        64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("ar_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    start = 1'b1;
    mode  = 2'd2;
    len   = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("ar_restart_valid", 64'(out_valid), 64'd1);
    chk("ar_restart_d0",    64'(d0),        64'd0);
    @(negedge clk);
    chk("ar_restart_d1", 64'(d0), 64'd1);
    @(negedge clk);
    chk("ar_restart_done", 64'(done),     64'd1);
    chk("ar_restart_cnt",  64'(beat_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arr_pattern_gen.md
ARR_PATTERN_GEN -- requirements
Module: arr_pattern_gen

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent output channels, range 1-8.
REQ-002 Parameter LANES, default 4: packed lanes per channel.
REQ-003 Parameter LANE_W, default 5: bits per lane; LANES*LANE_W SHALL be 1-64, otherwise elaboration fails.
REQ-004 Parameter SEED, default 64'h9E37_79B9_7F4A_7C15: reset seed; must be non-zero.
REQ-005 One clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begins a burst when IDLE; ignored otherwise.
REQ-008 mode  input  2  pattern select, sampled with start: 0 xorshift, 1 walking-one, 2 beat counter, 3 constant seed.
REQ-009 len  input  16  burst length in beats, sampled with start; 0 means 65536.
REQ-010 seed_load  input  1  loads seed_in into the state register; honoured only in IDLE.
REQ-011 seed_in  input  64  new seed; a value of 0 is replaced by SEED.
REQ-012 out_ready  input  1  consumer ready.
REQ-013 out_valid  output  1  beat present.
REQ-014 out_data  output  CHANNELS unpacked x [LANES][LANE_W] packed  per-channel beat data.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-017 beat_cnt  output  16  beats accepted in the current or last burst.

Function
REQ-018 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when the beat numbered len (last) is accepted; DONE->IDLE unconditionally after one cycle.
REQ-019 In RUN, out_valid SHALL be 1; a beat is accepted when out_valid && out_ready.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-021 The first beat SHALL be presented in the cycle after start (latency 1), with no bubbles between accepted beats.
REQ-022 The 64-bit state register s SHALL advance only on acceptance; in mode 0 it advances by s^=s<<13; s^=s>>7; s^=s<<17.
REQ-023 Channel c data = low LANES*LANE_W bits of (P rotated left by 8*c mod 64), where P is the mode pattern word.
REQ-024 P per mode: 0 -> s; 1 -> 64'b1 << (beat_cnt mod LANES*LANE_W); 2 -> beat_cnt zero-extended; 3 -> s with s not advanced.
REQ-025 beat_cnt SHALL clear on start and increment on every acceptance, wrapping 65535->0 when len=0.
REQ-026 start during RUN or DONE SHALL be ignored; seed_load during RUN SHALL be ignored.
REQ-027 If seed_load and start are both high in IDLE, the seed loads first and the burst uses the new seed.
REQ-028 done SHALL be high for exactly one cycle, in the DONE state.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, s=SEED, out_valid=0, busy=0, done=0, beat_cnt=0, and out_data=0 for all channels, including mid-burst.
REQ-030 After rst_n deasserts, the first start is honoured on the first rising edge.

Structure
REQ-031 Package arr_pattern_pkg SHALL hold the mode enum, the FSM state enum, the default SEED constant, and the xorshift step function.
REQ-032 One sub-module, apg_channel_map, SHALL perform the per-channel rotate and slice, instantiated CHANNELS times via generate.

Verification
REQ-033 Reset, then mode 0, len=3, out_ready=1 -> three beats, channel 0 beat 0 = SEED[19:0], done pulses once, and beat_cnt=3.
REQ-034 Mode 1, LANES=4, LANE_W=5, len=22 -> channel 0 walks bit 0..19 then returns to bit 0 on beats 21-22.
REQ-035 Mode 2, len=5, out_ready low for 4 cycles at beat 2 -> data holds 2, and the sequence is 0,1,2,3,4 with no beat lost.
REQ-036 seed_load with seed_in=0, then mode 3 -> every beat equals SEED slices; channel 1 equals SEED rotated by 8.
REQ-037 rst_n pulsed low at beat 2 of a len=10 burst -> all outputs 0 immediately, IDLE, and no done pulse.
REQ-038 start asserted during RUN -> ignored, and beat_cnt continues without a restart.
